// File: rtl/bus_cycle_seq.sv
// Multiplexed instruction-cycle bus sequencer: N address slots, M1/M2 fetch, X1..X3 execute.
// Optional memory wait states on M1/M2 are enabled with the BUS_WAIT_EN macro.
module bus_cycle_seq #(
   parameter int DATA_W    = 4,
   parameter int ADDR_W    = 12,
   parameter int RAM_BANKS = 4,
   parameter int WAIT_MAX  = 15
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [DATA_W-1:0]                    data_i,
   output logic [DATA_W-1:0]                    data_o,
   output logic                                 data_en,
   input  logic                                 ready,
   input  logic [ADDR_W-1:0]                    pc,
   input  logic [$clog2(RAM_BANKS)-1:0]         bank_sel,
   input  logic                                 io_cmd,
   input  logic                                 x_drive,
   input  logic [DATA_W-1:0]                    x_data,
   output logic                                 sync,
   output logic                                 rom_cmd,
   output logic [RAM_BANKS-1:0]                 ram_cmd_n,
   output logic [$clog2(ADDR_W/DATA_W+5)-1:0]   cycle,
   output logic [DATA_W-1:0]                    opr,
   output logic [DATA_W-1:0]                    opa,
   output logic                                 fetch_done,
   output logic [DATA_W-1:0]                    x2_data,
   output logic                                 bus_timeout
);

   localparam int N  = ADDR_W / DATA_W;
   localparam int CW = $clog2(N + 5);

   localparam logic [CW-1:0] SLOT_ALAST = CW'(N - 1);
   localparam logic [CW-1:0] SLOT_M1    = CW'(N);
   localparam logic [CW-1:0] SLOT_M2    = CW'(N + 1);
   localparam logic [CW-1:0] SLOT_X2    = CW'(N + 3);
   localparam logic [CW-1:0] SLOT_X3    = CW'(N + 4);

   logic [CW-1:0]     cycle_q, cycle_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] opr_q, opr_d, opa_q, opa_d, x2_q, x2_d;
   logic              advance;
   logic              timeout_set;

`ifdef BUS_WAIT_EN
   localparam int WW = $clog2(WAIT_MAX + 1);
   logic [WW-1:0] wait_q, wait_d;
   logic          timeout_q, timeout_d;
   logic          in_fetch, wait_hit;

   always_comb begin
      in_fetch    = (cycle_q == SLOT_M1) || (cycle_q == SLOT_M2);
      wait_hit    = (wait_q == WW'(WAIT_MAX));
      advance     = !(in_fetch && !ready && !wait_hit);
      timeout_set = in_fetch && !ready && wait_hit;
      wait_d      = advance ? '0 : wait_q + 1'b1;
      timeout_d   = timeout_q | timeout_set;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus_timeout = timeout_q;
`else
   logic unused_wait_ready;
   localparam int UNUSED_WAIT_MAX = WAIT_MAX;
   assign unused_wait_ready = ready;
   assign advance           = 1'b1;
   assign timeout_set       = 1'b0;
   assign bus_timeout       = 1'b0;
`endif

   // Slot sequencing and captures; M1/M2 only move on when the fetch actually completes.
   always_comb begin
      cycle_d = cycle_q;
      addr_d  = addr_q;
      opr_d   = opr_q;
      opa_d   = opa_q;
      x2_d    = x2_q;
      if (advance)
         cycle_d = (cycle_q == SLOT_X3) ? '0 : cycle_q + 1'b1;
      if (cycle_q == SLOT_M1 && advance)
         opr_d = data_i;
      if (cycle_q == SLOT_M2 && advance)
         opa_d = data_i;
      if (cycle_q == SLOT_X2)
         x2_d = data_i;
      if (cycle_q == SLOT_X3)
         addr_d = pc;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_q <= '0;
         addr_q  <= '0;
         opr_q   <= '0;
         opa_q   <= '0;
         x2_q    <= '0;
      end else begin
         cycle_q <= cycle_d;
         addr_q  <= addr_d;
         opr_q   <= opr_d;
         opa_q   <= opa_d;
         x2_q    <= x2_d;
      end
   end

   // Pin decode from the slot counter; all strobes are held quiet while reset is asserted.
   logic              a_slot, x2_slot, cmd_act;
   logic [DATA_W-1:0] a_nib;

   always_comb begin
      a_slot  = (cycle_q < CW'(N));
      x2_slot = (cycle_q == SLOT_X2);
      a_nib   = '0;
      for (int k = 0; k < N; k++)
         if (cycle_q == CW'(k))
            a_nib = addr_q[k*DATA_W +: DATA_W];
      cmd_act    = !reset && ((cycle_q == SLOT_ALAST) || (x2_slot && io_cmd));
      data_en    = !reset && (a_slot || (x2_slot && x_drive));
      data_o     = '0;
      if (!reset && a_slot)
         data_o = a_nib;
      else if (!reset && x2_slot && x_drive)
         data_o = x_data;
      sync       = !reset && (cycle_q == SLOT_X3);
      rom_cmd    = cmd_act;
      fetch_done = !reset && (cycle_q == SLOT_M2) && advance;
      ram_cmd_n  = '1;
      for (int b = 0; b < RAM_BANKS; b++)
         if (cmd_act && int'(bank_sel) == b)
            ram_cmd_n[b] = 1'b0;
   end

   assign cycle   = cycle_q;
   assign opr     = opr_q;
   assign opa     = opa_q;
   assign x2_data = x2_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Directed bench for bus_cycle_seq: default 4/12/4 instance plus an 8/16-bit, 3-bank instance.
module tb_bus_cycle_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        rst;
   logic [3:0]  data_i, x_data, data_o, opr, opa, x2_data;
   logic        ready, io_cmd, x_drive;
   logic [11:0] pc;
   logic [1:0]  bank_sel;
   logic        data_en, sync, rom_cmd, fetch_done, bus_timeout;
   logic [3:0]  ram_cmd_n;
   logic [2:0]  cycle;

   logic        rst_w;
   logic [7:0]  data_i_w, x_data_w, data_o_w, opr_w, opa_w, x2_data_w;
   logic [15:0] pc_w;
   logic [1:0]  bank_sel_w;
   logic        io_cmd_w, x_drive_w, ready_w;
   logic        data_en_w, sync_w, rom_cmd_w, fetch_done_w, bus_timeout_w;
   logic [2:0]  ram_cmd_n_w;
   logic [2:0]  cycle_w;

   bus_cycle_seq dut (
      .clock(clk), .reset(rst), .data_i(data_i), .data_o(data_o), .data_en(data_en),
      .ready(ready), .pc(pc), .bank_sel(bank_sel), .io_cmd(io_cmd), .x_drive(x_drive),
      .x_data(x_data), .sync(sync), .rom_cmd(rom_cmd), .ram_cmd_n(ram_cmd_n), .cycle(cycle),
      .opr(opr), .opa(opa), .fetch_done(fetch_done), .x2_data(x2_data), .bus_timeout(bus_timeout)
   );

   bus_cycle_seq #(.DATA_W(8), .ADDR_W(16), .RAM_BANKS(3)) dut_w (
      .clock(clk), .reset(rst_w), .data_i(data_i_w), .data_o(data_o_w), .data_en(data_en_w),
      .ready(ready_w), .pc(pc_w), .bank_sel(bank_sel_w), .io_cmd(io_cmd_w), .x_drive(x_drive_w),
      .x_data(x_data_w), .sync(sync_w), .rom_cmd(rom_cmd_w), .ram_cmd_n(ram_cmd_n_w), .cycle(cycle_w),
      .opr(opr_w), .opa(opa_w), .fetch_done(fetch_done_w), .x2_data(x2_data_w), .bus_timeout(bus_timeout_w)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; pc = 12'h3A5; data_i = '0; ready = 1'b1; bank_sel = '0;
      io_cmd = 1'b0; x_drive = 1'b0; x_data = '0;
      tick(); tick(); #1;
      total++; if (cycle !== 3'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", cycle); end
      total++; if (data_en !== 1'b0 || data_o !== 4'h0) begin bad++; $display("FAIL reset_data got en=%b o=%h exp en=0 o=0", data_en, data_o); end
      total++; if (opr !== 4'h0 || opa !== 4'h0 || x2_data !== 4'h0) begin bad++; $display("FAIL reset_regs got opr=%h opa=%h x2=%h exp 0", opr, opa, x2_data); end
      total++; if (sync !== 1'b0 || rom_cmd !== 1'b0 || fetch_done !== 1'b0 || bus_timeout !== 1'b0) begin bad++; $display("FAIL reset_strobes got s=%b r=%b f=%b t=%b exp 0", sync, rom_cmd, fetch_done, bus_timeout); end
      total++; if (ram_cmd_n !== 4'hF) begin bad++; $display("FAIL reset_ram got=%b exp=1111", ram_cmd_n); end
      rst = 1'b0;
   endtask

   task automatic test_frame();
      logic [11:0] exp_addr;
      for (int f = 0; f < 2; f++) begin
         exp_addr = (f == 0) ? 12'h000 : 12'h3A5;
         for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (cycle !== 3'(i)) begin bad++; $display("FAIL frame_cycle got=%0d exp=%0d", cycle, i); end
            total++; if (sync !== (i == 7)) begin bad++; $display("FAIL frame_sync slot=%0d got=%b exp=%b", i, sync, (i == 7)); end
            if (i < 3) begin
               total++; if (data_en !== 1'b1 || data_o !== exp_addr[i*4 +: 4]) begin bad++; $display("FAIL frame_addr slot=%0d got en=%b o=%h exp en=1 o=%h", i, data_en, data_o, exp_addr[i*4 +: 4]); end
            end
            tick();
         end
      end
   endtask

   task automatic test_fetch();
      tick(); tick(); tick();
      data_i = 4'hD; #1;
      total++; if (cycle !== 3'd3 || data_en !== 1'b0 || fetch_done !== 1'b0) begin bad++; $display("FAIL fetch_m1 got cyc=%0d en=%b fd=%b exp cyc=3 en=0 fd=0", cycle, data_en, fetch_done); end
      tick(); data_i = 4'h7; #1;
      total++; if (opr !== 4'hD) begin bad++; $display("FAIL fetch_opr got=%h exp=d", opr); end
      total++; if (fetch_done !== 1'b1 || cycle !== 3'd4) begin bad++; $display("FAIL fetch_done_m2 got fd=%b cyc=%0d exp fd=1 cyc=4", fetch_done, cycle); end
      tick(); data_i = 4'h0; #1;
      total++; if (opa !== 4'h7 || fetch_done !== 1'b0) begin bad++; $display("FAIL fetch_opa got opa=%h fd=%b exp opa=7 fd=0", opa, fetch_done); end
      tick(); data_i = 4'hC;
      tick(); data_i = 4'h0; #1;
      total++; if (x2_data !== 4'hC || cycle !== 3'd7) begin bad++; $display("FAIL fetch_x2 got x2=%h cyc=%0d exp x2=c cyc=7", x2_data, cycle); end
      tick();
   endtask

   task automatic test_io_cmd();
      logic exp_rom;
      bank_sel = 2'd2; io_cmd = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_rom = (i == 2) || (i == 6);
         #1;
         total++; if (rom_cmd !== exp_rom) begin bad++; $display("FAIL io_rom slot=%0d got=%b exp=%b", i, rom_cmd, exp_rom); end
         total++; if (ram_cmd_n !== (exp_rom ? 4'b1011 : 4'b1111)) begin bad++; $display("FAIL io_ram slot=%0d got=%b exp=%b", i, ram_cmd_n, (exp_rom ? 4'b1011 : 4'b1111)); end
         tick();
      end
      io_cmd = 1'b0; bank_sel = 2'd0;
   endtask

   task automatic test_x_drive();
      logic [11:0] a;
      logic        exp_en;
      logic [3:0]  exp_o;
      a = 12'h3A5;
      x_drive = 1'b1; x_data = 4'h9;
      for (int i = 0; i < 8; i++) begin
         exp_en = (i < 3) || (i == 6);
         exp_o  = (i < 3) ? a[i*4 +: 4] : ((i == 6) ? 4'h9 : 4'h0);
         #1;
         total++; if (data_en !== exp_en || data_o !== exp_o) begin bad++; $display("FAIL xdrive slot=%0d got en=%b o=%h exp en=%b o=%h", i, data_en, data_o, exp_en, exp_o); end
         tick();
      end
      x_drive = 1'b0; x_data = 4'h0;
   endtask

   task automatic test_wait();
      int n;
`ifdef BUS_WAIT_EN
      tick(); tick(); tick();
      ready = 1'b0; data_i = 4'h1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (cycle !== 3'd3 || fetch_done !== 1'b0) begin bad++; $display("FAIL wait_hold_m1 i=%0d got cyc=%0d fd=%b exp cyc=3 fd=0", i, cycle, fetch_done); end
         tick();
      end
      ready = 1'b1; data_i = 4'hE;
      tick(); data_i = 4'h0; #1;
      total++; if (opr !== 4'hE || cycle !== 3'd4) begin bad++; $display("FAIL wait_opr got opr=%h cyc=%0d exp opr=e cyc=4", opr, cycle); end
      tick(); tick(); tick(); tick(); #1;
      total++; if (cycle !== 3'd0 || bus_timeout !== 1'b0) begin bad++; $display("FAIL wait_frame11 got cyc=%0d to=%b exp cyc=0 to=0", cycle, bus_timeout); end
      tick(); tick(); tick(); tick();
      ready = 1'b0; data_i = 4'h6;
      n = 0;
      while (cycle === 3'd4 && n < 20) begin
         #1;
         total++; if (fetch_done !== (n == 15)) begin bad++; $display("FAIL wait_fd n=%0d got=%b exp=%b", n, fetch_done, (n == 15)); end
         tick();
         n++;
      end
      ready = 1'b1; data_i = 4'h0; #1;
      total++; if (n !== 16) begin bad++; $display("FAIL wait_m2_len got=%0d exp=16", n); end
      total++; if (bus_timeout !== 1'b1 || opa !== 4'h6) begin bad++; $display("FAIL wait_timeout got to=%b opa=%h exp to=1 opa=6", bus_timeout, opa); end
      tick(); tick(); tick(); #1;
      total++; if (cycle !== 3'd0 || bus_timeout !== 1'b1) begin bad++; $display("FAIL wait_sticky got cyc=%0d to=%b exp cyc=0 to=1", cycle, bus_timeout); end
`else
      ready = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++; if (cycle !== 3'(i) || fetch_done !== (i == 4)) begin bad++; $display("FAIL noready slot=%0d got cyc=%0d fd=%b exp cyc=%0d fd=%b", i, cycle, fetch_done, i, (i == 4)); end
         if (bus_timeout !== 1'b0) n++;
         tick();
      end
      ready = 1'b1; #1;
      total++; if (n !== 0 || cycle !== 3'd0) begin bad++; $display("FAIL noready_end got to_cycles=%0d cyc=%0d exp 0 0", n, cycle); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [11:0] a;
      pc = 12'h5C1; x_drive = 1'b1; x_data = 4'h9;
      for (int i = 0; i < 6; i++) tick();
      #1;
      total++; if (cycle !== 3'd6 || data_en !== 1'b1 || data_o !== 4'h9) begin bad++; $display("FAIL rmid_x2 got cyc=%0d en=%b o=%h exp 6 1 9", cycle, data_en, data_o); end
      rst = 1'b1;
      tick(); #1;
      total++; if (cycle !== 3'd0 || data_en !== 1'b0 || data_o !== 4'h0) begin bad++; $display("FAIL rmid_next got cyc=%0d en=%b o=%h exp 0 0 0", cycle, data_en, data_o); end
      total++; if (opr !== 4'h0 || opa !== 4'h0 || bus_timeout !== 1'b0) begin bad++; $display("FAIL rmid_regs got opr=%h opa=%h to=%b exp 0 0 0", opr, opa, bus_timeout); end
      rst = 1'b0;
      for (int f = 0; f < 2; f++) begin
         a = (f == 0) ? 12'h000 : 12'h5C1;
         for (int i = 0; i < 8; i++) begin
            #1;
            if (i < 3) begin
               total++; if (data_en !== 1'b1 || data_o !== a[i*4 +: 4]) begin bad++; $display("FAIL rmid_addr f=%0d slot=%0d got en=%b o=%h exp en=1 o=%h", f, i, data_en, data_o, a[i*4 +: 4]); end
            end
            tick();
         end
      end
      x_drive = 1'b0; x_data = 4'h0;
   endtask

   task automatic test_wide();
      logic [15:0] a;
      logic        exp_rom;
      logic [2:0]  exp_ram;
      pc_w = 16'hBEEF; bank_sel_w = 2'd3; io_cmd_w = 1'b1;
      tick();
      rst_w = 1'b0;
      for (int f = 0; f < 3; f++) begin
         a = (f == 0) ? 16'h0000 : 16'hBEEF;
         if (f == 2) bank_sel_w = 2'd1;
         for (int i = 0; i < 7; i++) begin
            exp_rom = (i == 1) || (i == 5);
            exp_ram = (f == 2 && exp_rom) ? 3'b101 : 3'b111;
            #1;
            total++; if (cycle_w !== 3'(i) || sync_w !== (i == 6)) begin bad++; $display("FAIL wide_slot f=%0d got cyc=%0d sync=%b exp cyc=%0d sync=%b", f, cycle_w, sync_w, i, (i == 6)); end
            total++; if (rom_cmd_w !== exp_rom || ram_cmd_n_w !== exp_ram) begin bad++; $display("FAIL wide_cmd f=%0d slot=%0d got rom=%b ram=%b exp rom=%b ram=%b", f, i, rom_cmd_w, ram_cmd_n_w, exp_rom, exp_ram); end
            if (i < 2) begin
               total++; if (data_o_w !== a[i*8 +: 8]) begin bad++; $display("FAIL wide_addr f=%0d slot=%0d got=%h exp=%h", f, i, data_o_w, a[i*8 +: 8]); end
            end
            tick();
         end
      end
   endtask

   initial begin
      rst = 1'b1; rst_w = 1'b1;
      data_i_w = '0; x_data_w = '0; pc_w = '0; bank_sel_w = '0;
      io_cmd_w = 1'b0; x_drive_w = 1'b0; ready_w = 1'b1;
      test_reset();
      test_frame();
      test_fetch();
      test_io_cmd();
      test_x_drive();
      test_wait();
      test_reset_mid();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
